// File: rtl/sequential_logical_reducer.sv
// Multi-cycle logical reducer: scans W bits per clock of each N-bit operand and combines (|a),(|b) via op.
// Optional SEQ_LOGICAL_REDUCER_EARLY_EXIT_EN lets OR/AND finish as soon as the result is decided.
module sequential_logical_reducer #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         c,
    output logic         busy
);

    localparam int NCH = N / W;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    if (N < 1 || W < 1 || W > N || (N % W) != 0) begin : g_param_check
        $error("sequential_logical_reducer: need 1 <= W <= N and N %% W == 0");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OP_OR, OP_AND, OP_XOR, OP_XNOR} op_t;

    state_t         state, state_n;
    op_t            op_r, op_n;
    logic [N-1:0]   sa, sa_n, sb, sb_n;
    logic           acc_a, acc_a_n, acc_b, acc_b_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           c_r, c_n;

    logic           acc_a_nxt, acc_b_nxt, last_chunk, finish;

    function automatic logic combine(input op_t o, input logic x, input logic y);
        case (o)
            OP_OR:   return x | y;
            OP_AND:  return x & y;
            OP_XOR:  return x ^ y;
            default: return ~(x ^ y);
        endcase
    endfunction

    assign acc_a_nxt  = acc_a | (|sa[W-1:0]);
    assign acc_b_nxt  = acc_b | (|sb[W-1:0]);
    assign last_chunk = (cnt == CW'(NCH - 1));

`ifdef SEQ_LOGICAL_REDUCER_EARLY_EXIT_EN
    assign finish = last_chunk
                  || ((op_r == OP_OR)  && (acc_a_nxt | acc_b_nxt))
                  || ((op_r == OP_AND) && (acc_a_nxt & acc_b_nxt));
`else
    assign finish = last_chunk;
`endif

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign c         = c_r;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_n = state;
        op_n    = op_r;
        sa_n    = sa;
        sb_n    = sb;
        acc_a_n = acc_a;
        acc_b_n = acc_b;
        cnt_n   = cnt;
        c_n     = c_r;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sa_n    = a;
                    sb_n    = b;
                    op_n    = op_t'(op);
                    acc_a_n = 1'b0;
                    acc_b_n = 1'b0;
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                acc_a_n = acc_a_nxt;
                acc_b_n = acc_b_nxt;
                sa_n    = sa >> W;
                sb_n    = sb >> W;
                cnt_n   = cnt + CW'(1);
                if (finish) begin
                    state_n = DONE;
                    c_n     = combine(op_r, acc_a_nxt, acc_b_nxt);
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_r  <= OP_OR;
            acc_a <= 1'b0;
            acc_b <= 1'b0;
            cnt   <= '0;
            c_r   <= 1'b0;
        end else begin
            state <= state_n;
            op_r  <= op_n;
            acc_a <= acc_a_n;
            acc_b <= acc_b_n;
            cnt   <= cnt_n;
            c_r   <= c_n;
        end
    end

    // NOTE: operand shift registers are pure datapath, always loaded on acceptance, so they carry no reset.
    always_ff @(posedge clk) begin
        sa <= sa_n;
        sb <= sb_n;
    end

endmodule

// File: tb/tb_sequential_logical_reducer.sv
// Randomized self-checking bench for sequential_logical_reducer (N=8/W=2 and N=4/W=4 instances).
// Latency expectations follow SEQ_LOGICAL_REDUCER_EARLY_EXIT_EN when it is defined.
module tb_sequential_logical_reducer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, c, busy;
    logic [7:0] a, b;
    logic [1:0] op;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, c4, busy4;
    logic [3:0] a4, b4;
    logic [1:0] op4;

    int checks = 0;
    int errors = 0;

    sequential_logical_reducer #(.N(8), .W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .busy(busy)
    );

    sequential_logical_reducer #(.N(4), .W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .op(op4), .out_valid(out_valid4), .out_ready(out_ready4),
        .c(c4), .busy(busy4)
    );

    // Reference: truth values of whole operands combined by op.
    function automatic logic model_c(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv);
        logic ta, tb;
        ta = (av != 0);
        tb = (bv != 0);
        case (o)
            2'd0:    return ta | tb;
            2'd1:    return ta & tb;
            2'd2:    return ta ^ tb;
            default: return !(ta ^ tb);
        endcase
    endfunction

    // Reference latency: number of chunks until the result is known (all chunks without early exit).
    function automatic int model_lat(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                                     input int n, input int w);
        int nch;
        nch = n / w;
`ifdef SEQ_LOGICAL_REDUCER_EARLY_EXIT_EN
        for (int i = 0; i < nch; i++) begin
            int mask;
            logic [7:0] m8;
            logic pa, pb;
            mask = (1 << ((i + 1) * w)) - 1;
            m8 = mask[7:0];
            pa = ((av & m8) != 0);
            pb = ((bv & m8) != 0);
            if (o == 2'd0 && (pa || pb)) return i + 1;
            if (o == 2'd1 && (pa && pb)) return i + 1;
        end
`endif
        return nch;
    endfunction

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Issue one op, scramble the operand inputs right after acceptance, and wait for the result.
    task automatic run_op(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                          output int lat, output logic cv, output logic acc_ok);
        @(negedge clk);
        acc_ok = in_ready;
        in_valid = 1'b1; a = av; b = bv; op = o; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
        wait_out(lat);
        cv = c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; out_ready = 0; a = 0; b = 0; op = 0;
        in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; op4 = 0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
            checks++; if (c !== 1'b0) begin errors++; $display("FAIL reset_c got=%b exp=0", c); end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_or();
        logic [7:0] ta [3] = '{8'h00, 8'h00, 8'h01};
        logic [7:0] tb [3] = '{8'h40, 8'h00, 8'h00};
        int lat; logic cv, acc;
        for (int i = 0; i < 3; i++) begin
            run_op(2'd0, ta[i], tb[i], lat, cv, acc);
            checks++; if (cv !== model_c(2'd0, ta[i], tb[i])) begin errors++; $display("FAIL or_c[%0d] got=%b exp=%b", i, cv, model_c(2'd0, ta[i], tb[i])); end
            checks++; if (lat != model_lat(2'd0, ta[i], tb[i], 8, 2)) begin errors++; $display("FAIL or_lat[%0d] got=%0d exp=%0d", i, lat, model_lat(2'd0, ta[i], tb[i], 8, 2)); end
        end
    endtask

    task automatic test_all_ops();
        logic [7:0] bv [2] = '{8'h00, 8'h01};
        int lat; logic cv, acc;
        for (int k = 0; k < 2; k++) begin
            for (int o = 0; o < 4; o++) begin
                run_op(2'(o), 8'h80, bv[k], lat, cv, acc);
                checks++; if (cv !== model_c(2'(o), 8'h80, bv[k])) begin errors++; $display("FAIL ops_c op=%0d b=%h got=%b exp=%b", o, bv[k], cv, model_c(2'(o), 8'h80, bv[k])); end
                checks++; if (lat != model_lat(2'(o), 8'h80, bv[k], 8, 2)) begin errors++; $display("FAIL ops_lat op=%0d got=%0d exp=%0d", o, lat, model_lat(2'(o), 8'h80, bv[k], 8, 2)); end
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        in_valid = 1'b1; a = 8'h80; b = 8'h00; op = 2'd2; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        checks++; if (lat != model_lat(2'd2, 8'h80, 8'h00, 8, 2)) begin errors++; $display("FAIL bp_lat got=%0d exp=%0d", lat, model_lat(2'd2, 8'h80, 8'h00, 8, 2)); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL bp_c got=%b exp=1", c); end
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            #1;
            checks++; if (out_valid !== 1'b1 || c !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold got ov=%b c=%b ir=%b exp ov=1 c=1 ir=0", out_valid, c, in_ready);
            end
        end
        a = 8'h00; b = 8'h00; op = 2'd0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || c !== 1'b1) begin
            errors++; $display("FAIL bp_release got ov=%b ir=%b c=%b exp ov=0 ir=1 c=1", out_valid, in_ready, c);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_accept_next got busy=%b exp=1", busy); end
        wait_out(lat);
        checks++; if (lat != model_lat(2'd0, 8'h00, 8'h00, 8, 2) || c !== 1'b0) begin
            errors++; $display("FAIL bp_second got lat=%0d c=%b exp lat=%0d c=0", lat, c, model_lat(2'd0, 8'h00, 8'h00, 8, 2));
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic cv, acc;
        run_op(2'd0, 8'h80, 8'h00, lat, cv, acc);
        checks++; if (cv !== 1'b1) begin errors++; $display("FAIL rm_pre_c got=%b exp=1", cv); end
        @(negedge clk);
        in_valid = 1'b1; a = 8'h80; b = 8'h00; op = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rm_during got ir=%b busy=%b exp ir=0 busy=1", in_ready, busy); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || c !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rm_after got ov=%b c=%b busy=%b exp 0 0 0", out_valid, c, busy);
        end
        rst = 1'b0;
        run_op(2'd0, 8'h02, 8'h00, lat, cv, acc);
        checks++; if (cv !== 1'b1 || lat != model_lat(2'd0, 8'h02, 8'h00, 8, 2)) begin
            errors++; $display("FAIL rm_next got c=%b lat=%0d exp c=1 lat=%0d", cv, lat, model_lat(2'd0, 8'h02, 8'h00, 8, 2));
        end
    endtask

    task automatic test_w_eq_n();
        logic [3:0] ta [2] = '{4'h8, 4'h8};
        logic [3:0] tb [2] = '{4'h0, 4'h1};
        for (int i = 0; i < 2; i++) begin
            int lat;
            logic expc;
            expc = model_c(2'd1, {4'h0, ta[i]}, {4'h0, tb[i]});
            @(negedge clk);
            in_valid4 = 1'b1; a4 = ta[i]; b4 = tb[i]; op4 = 2'd1; out_ready4 = 1'b1;
            @(negedge clk);
            in_valid4 = 1'b0; a4 = ~ta[i]; b4 = ~tb[i];
            lat = 0;
            while (out_valid4 !== 1'b1 && lat < 64) begin
                @(negedge clk);
                lat++;
            end
            checks++; if (lat != model_lat(2'd1, {4'h0, ta[i]}, {4'h0, tb[i]}, 4, 4)) begin errors++; $display("FAIL weqn_lat[%0d] got=%0d exp=1", i, lat); end
            checks++; if (c4 !== expc) begin errors++; $display("FAIL weqn_c[%0d] got=%b exp=%b", i, c4, expc); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0] o;
            logic [7:0] av, bv;
            int lat; logic cv, acc;
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       av = 8'h00;
                1:       av = 8'(1 << $urandom_range(0, 7));
                default: av = 8'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       bv = 8'h00;
                1:       bv = 8'(1 << $urandom_range(0, 7));
                default: bv = 8'($urandom);
            endcase
            run_op(o, av, bv, lat, cv, acc);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL rnd_ready[%0d] got=%b exp=1", i, acc); end
            checks++; if (cv !== model_c(o, av, bv)) begin errors++; $display("FAIL rnd_c[%0d] op=%0d a=%h b=%h got=%b exp=%b", i, o, av, bv, cv, model_c(o, av, bv)); end
            checks++; if (lat != model_lat(o, av, bv, 8, 2)) begin errors++; $display("FAIL rnd_lat[%0d] op=%0d a=%h b=%h got=%0d exp=%0d", i, o, av, bv, lat, model_lat(o, av, bv, 8, 2)); end
        end
    endtask

    initial begin
        test_reset();
        test_or();
        test_all_ops();
        test_backpressure();
        test_reset_mid();
        test_w_eq_n();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=expired exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sequential_logical_reducer.md
Name: sequential_logical_reducer

Overview:
- Multi-cycle, handshaked counterpart to the combinational logical-reduction units in BasicCombinationalLogic/Logical.
- Accepts two N-bit operands and reduces each to a truth value by scanning W bits per clock.
- Combines the two truth values with a selectable logical operator.
- Used where a full N-wide OR tree misses timing: it trades latency for area and depth behind valid/ready interfaces.

Parameters:
- N, 8, operand width in bits; must be ≥1.
- W, 2, bits scanned per cycle per operand; 1 ≤ W ≤ N; N % W != 0 is an elaboration error ($error).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept a new operation.
- a  input  N  operand A.
- b  input  N  operand B.
- op  input  2  00 OR, 01 AND, 10 XOR, 11 XNOR of (|a),(|b).
- out_valid  output  1  result c valid.
- out_ready  input  1  downstream accepts result.
- c  output  1  logical result.
- busy  output  1  high in BUSY state.

Behaviour:
Interface decision:
- One clock; reset is synchronous and active-high (ports clk, rst).

Reset:
- rst sampled at clk edge overrides all other activity, including mid-operation and while out_valid is high.
- After reset: state=IDLE, out_valid=0, c=0, busy=0, accumulators=0, counter=0.
- in_ready = (state==IDLE) && !rst, so it is 0 during any reset cycle.

States: IDLE, BUSY, DONE.

IDLE:
- in_ready=1.
- On in_valid&&in_ready:
  - capture a, b into shift registers sa, sb; capture op;
  - clear accA, accB and the chunk counter cnt (width clog2(N/W), min 1);
  - go to BUSY.
- in_valid without acceptance has no effect.

BUSY:
- Each edge: accA |= |sa[W-1:0]; accB |= |sb[W-1:0]; shift sa, sb right by W; cnt++.
- On the edge that processes chunk N/W-1:
  - go to DONE;
  - register c = f(op, accA_next, accB_next).
- in_ready=0 and in_valid is ignored.

DONE:
- out_valid=1; c stable.
- On out_ready go to IDLE and clear out_valid.
- No new operation is accepted in the same cycle; next acceptance is one cycle later.
- out_ready while not in DONE has no effect.

Latency and throughput:
- out_valid rises exactly N/W edges after the accepting edge.
- Throughput: one op per N/W+2 cycles minimum.

Functions:
- f(00) = A|B; f(01) = A&B; f(10) = A^B; f(11) = ~(A^B).

Boundary conditions:
- W=N gives a single BUSY cycle.
- All-zero operands give A=B=0.
- Operands are sampled only at acceptance; changes on a and b during BUSY have no effect.
- c is held until the next result; it is cleared only by reset.

Optional Feature:
Macro: SEQ_LOGICAL_REDUCER_EARLY_EXIT_EN

Defined:
- In BUSY, if the result is already decided after the current chunk, go to DONE on that edge with the final c:
  - OR: accA_next|accB_next = 1;
  - AND: accA_next&accB_next = 1.
- XOR and XNOR never exit early.
- Latency for OR and AND becomes 1..N/W edges.

Undefined:
- Fixed latency N/W for all ops; no early-exit logic is synthesised.

Test Plan (N=8, W=2 unless noted):
1. Reset: hold rst 2 cycles -> in_ready=0, out_valid=0, c=0 during reset; after release in_ready=1, busy=0.
2. OR, a=8'h00, b=8'h40, out_ready=1 -> out_valid 4 edges after accept, c=1. Repeat with a=b=0 -> c=0. With EARLY_EXIT_EN: a=8'h01 -> out_valid 1 edge after accept.
3. All ops, a=8'h80, b=8'h00 -> OR 1, AND 0, XOR 1, XNOR 0. Then a=8'h80, b=8'h01 -> AND 1, XOR 0, XNOR 1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid; drive in_valid=1 with new operands -> out_valid and c stay stable, in_ready=0. Release out_ready -> IDLE next edge; new op accepted the following edge.
5. Reset mid-operation: assert rst on the 2nd BUSY cycle -> IDLE next edge, out_valid=0, c=0. A subsequent op a=8'h02, b=0, OR -> c=1 with normal latency.
6. N=4, W=4: a=4'h8, b=0, AND -> out_valid 1 edge after accept, c=0. Operand change on a during BUSY (any config) -> result reflects captured values.
